// File: rtl/piradip_fifo_arb_pkg.sv
// Shared types and tag packing for the FIFO write arbiter.
// The read-side demux unpacks with the same layout helpers.
package piradip_fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int TAG_MAX_DATA = 1024;
  localparam int TAG_MAX_ID   = 4;
  localparam int TAG_MAX      = TAG_MAX_DATA + TAG_MAX_ID + 1;

  typedef logic [TAG_MAX-1:0] tag_t;

  // Layout is {id, last, data}; callers truncate to their own width.
  function automatic tag_t tag_pack(
    input logic [TAG_MAX_ID-1:0]   id,
    input logic                    last,
    input logic [TAG_MAX_DATA-1:0] data,
    input int                      width
  );
    tag_t t;
    t = tag_t'(data);
    t = t | (tag_t'(last) << width);
    t = t | (tag_t'(id) << (width + 1));
    return t;
  endfunction

  function automatic logic tag_last(
    input tag_t t,
    input int   width
  );
    return t[width];
  endfunction

  function automatic logic [TAG_MAX_ID-1:0] tag_id(
    input tag_t t,
    input int   width
  );
    return TAG_MAX_ID'(t >> (width + 1));
  endfunction

endpackage

// File: rtl/piradip_fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin pick: rotate past rr_last,
// take the lowest set request, rotate the index back.
module piradip_rr_picker #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] rr_last,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx
);

  logic [N_REQ-1:0] rot;
  int base;
  int hit;

  always_comb begin
    rot  = '0;
    hit  = 0;
    base = (int'(rr_last) + 1) % N_REQ;
    for (int j = 0; j < N_REQ; j++)
      rot[j] = req[(base + j) % N_REQ];
    for (int j = N_REQ - 1; j >= 0; j--)
      if (rot[j]) hit = j;
    any = |rot;
    idx = ID_WIDTH'((base + hit) % N_REQ);
  end

endmodule

// File: rtl/piradip_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among
// N_REQ streams; grants last until s_last or MAX_BURST beats.
module piradip_fifo_wr_arbiter
  import piradip_fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            s_valid,
  input  logic [N_REQ*WIDTH-1:0]      s_data,
  input  logic [N_REQ-1:0]            s_last,
  output logic [N_REQ-1:0]            s_ready,
  output logic                        fifo_we,
  output logic [WIDTH+$clog2(N_REQ):0] fifo_din,
  input  logic                        fifo_full,
  input  logic                        fifo_wr_rst_busy,
  output logic                        grant_valid,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic [7:0]                  beat_count
);

  localparam int ID_WIDTH   = $clog2(N_REQ);
  localparam int FIFO_WIDTH = WIDTH + ID_WIDTH + 1;

  arb_state_t state, state_nx;
  logic [ID_WIDTH-1:0] rr_last;
  logic [ID_WIDTH-1:0] pick_idx;
  logic pick_any;
  logic start, done;
  logic g_valid, g_last, g_ready, xfer;
  logic [WIDTH-1:0] g_data;
  logic [TAG_MAX_DATA-1:0] d_ext;
  logic [TAG_MAX_ID-1:0] id_ext;

  piradip_rr_picker #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req     (s_valid),
    .rr_last (rr_last),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  assign g_valid = s_valid[grant_id];
  assign g_last  = s_last[grant_id];
  assign g_data  = s_data[int'(grant_id)*WIDTH +: WIDTH];
  assign g_ready = !fifo_full && !fifo_wr_rst_busy;
  assign xfer    = (state == GRANT) && g_valid && g_ready;
  assign start   = (state == IDLE) && pick_any
                   && !fifo_wr_rst_busy;
  assign done    = xfer && (g_last ||
                   beat_count == 8'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_count  <= '0;
      rr_last     <= ID_WIDTH'(N_REQ - 1);
    end else begin
      state <= state_nx;
      if (start) begin
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
        beat_count  <= '0;
      end else if (done) begin
        rr_last     <= grant_id;
        grant_valid <= 1'b0;
        beat_count  <= '0;
      end else if (xfer) begin
        beat_count  <= beat_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = GRANT;
      GRANT: if (done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = '0;
    fifo_we  = 1'b0;
    fifo_din = '0;
    d_ext    = '0;
    id_ext   = '0;
    d_ext[WIDTH-1:0]     = g_data;
    id_ext[ID_WIDTH-1:0] = grant_id;
    if (state == GRANT)
      s_ready[grant_id] = g_ready;
    if (xfer) begin
      fifo_we  = 1'b1;
      fifo_din = FIFO_WIDTH'(
        tag_pack(id_ext, g_last, d_ext, WIDTH));
    end
  end

endmodule

// File: tb/tb_piradip_fifo_wr_arbiter.sv
// Directed bench: cycle vector table plus burst-split,
// stall, write-reset-busy and async-reset sequences.
module tb_piradip_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 8;
  localparam int FW = 35;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   s_valid, s_last, s_ready;
  logic [N*W-1:0] s_data;
  logic           fifo_we, fifo_full, fifo_wr_rst_busy;
  logic [FW-1:0]  fifo_din;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic [7:0]     beat_count;

  piradip_fifo_wr_arbiter #(
    .N_REQ(N), .WIDTH(W), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready),
    .fifo_we(fifo_we), .fifo_din(fifo_din),
    .fifo_full(fifo_full),
    .fifo_wr_rst_busy(fifo_wr_rst_busy),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  sv, sl;
    logic [15:0] beats;
    logic        full, busy;
    logic        e_we, e_last, e_gv;
    logic [1:0]  e_gid;
    logic [7:0]  e_bc;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(int i, int b);
    return 32'hA000_0000 | (32'(i) << 8) | 32'(b);
  endfunction

  function automatic logic [FW-1:0] din_of(
    logic [1:0] id, logic last, logic [31:0] d);
    return {id, last, d};
  endfunction

  task automatic add(
    logic [3:0] sv, logic [3:0] sl, logic [15:0] bt,
    logic f, logic b, logic we, logic l, logic gv,
    logic [1:0] gid, logic [7:0] bc, logic [3:0] rdy);
    vec_t v;
    v.sv = sv; v.sl = sl; v.beats = bt;
    v.full = f; v.busy = b;
    v.e_we = we; v.e_last = l; v.e_gv = gv;
    v.e_gid = gid; v.e_bc = bc; v.e_rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic apply(vec_t v);
    s_valid = v.sv;
    s_last  = v.sl;
    fifo_full = v.full;
    fifo_wr_rst_busy = v.busy;
    for (int i = 0; i < N; i++)
      s_data[i*W +: W] = dat(i, int'(v.beats[i*4 +: 4]));
  endtask

  task automatic idle_inputs();
    s_valid = '0; s_last = '0; s_data = '0;
    fifo_full = 1'b0; fifo_wr_rst_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [FW-1:0] got_q[$];
  logic [FW-1:0] exp_q[$];
  int c1, c3, cyc, last_cyc;
  bit done;

  initial begin
    // Reset state
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_gv", 64'(grant_valid), 0);
    chk("rst_we", 64'(fifo_we), 0);
    chk("rst_rdy", 64'(s_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_gid", 64'(grant_id), 0);
    chk("rst_bc", 64'(beat_count), 0);
    chk("rst_din", 64'(fifo_din), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("quiet_gv", 64'(grant_valid), 0);
      chk("quiet_rdy", 64'(s_ready), 0);
      chk("quiet_we", 64'(fifo_we), 0);
    end

    // Cycle table: sv sl beats full busy | we last gv gid bc rdy
    add(4'h5, 4'h0, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'h5, 4'h0, 16'h0000, 0,0, 1,0,1,0,0,4'h1);
    add(4'h5, 4'h0, 16'h0001, 0,0, 1,0,1,0,1,4'h1);
    add(4'h5, 4'h1, 16'h0002, 0,0, 1,1,1,0,2,4'h1);
    add(4'h4, 4'h0, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'h4, 4'h0, 16'h0000, 0,0, 1,0,1,2,0,4'h4);
    add(4'h4, 4'h0, 16'h0100, 0,0, 1,0,1,2,1,4'h4);
    add(4'h4, 4'h4, 16'h0200, 0,0, 1,1,1,2,2,4'h4);
    add(4'h0, 4'h0, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'hF, 4'hF, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'hF, 4'hF, 16'h0000, 0,0, 1,1,1,3,0,4'h8);
    add(4'hF, 4'hF, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'hF, 4'hF, 16'h0000, 0,0, 1,1,1,0,0,4'h1);
    add(4'h0, 4'h0, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'h2, 4'h0, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'h2, 4'h0, 16'h0000, 0,0, 1,0,1,1,0,4'h2);
    add(4'h2, 4'h0, 16'h0010, 0,0, 1,0,1,1,1,4'h2);
    add(4'h2, 4'h0, 16'h0020, 0,0, 1,0,1,1,2,4'h2);
    for (int k = 0; k < 5; k++)
      add(4'h2, 4'h2, 16'h0030, 1,0, 0,0,1,1,3,4'h0);
    add(4'h2, 4'h2, 16'h0030, 0,0, 1,1,1,1,3,4'h2);
    add(4'hF, 4'h0, 16'h0000, 0,1, 0,0,0,0,0,4'h0);
    add(4'hF, 4'h0, 16'h0000, 0,1, 0,0,0,0,0,4'h0);
    add(4'hF, 4'h0, 16'h0000, 0,0, 0,0,0,0,0,4'h0);
    add(4'hF, 4'h0, 16'h0000, 0,1, 0,0,1,2,0,4'h0);
    add(4'hF, 4'h4, 16'h0000, 0,0, 1,1,1,2,0,4'h4);
    add(4'h0, 4'h0, 16'h0000, 0,0, 0,0,0,0,0,4'h0);

    do_reset();
    foreach (vecs[k]) begin
      vec_t v;
      logic [FW-1:0] ed;
      v = vecs[k];
      apply(v);
      ed = '0;
      if (v.e_we)
        ed = din_of(v.e_gid, v.e_last,
               dat(int'(v.e_gid),
                   int'(v.beats[int'(v.e_gid)*4 +: 4])));
      @(negedge clk);
      chk($sformatf("v%0d_we", k), 64'(fifo_we), 64'(v.e_we));
      chk($sformatf("v%0d_din", k), 64'(fifo_din), 64'(ed));
      chk($sformatf("v%0d_gv", k), 64'(grant_valid), 64'(v.e_gv));
      if (v.e_gv)
        chk($sformatf("v%0d_gid", k), 64'(grant_id),
            64'(v.e_gid));
      chk($sformatf("v%0d_bc", k), 64'(beat_count), 64'(v.e_bc));
      chk($sformatf("v%0d_rdy", k), 64'(s_ready), 64'(v.e_rdy));
      @(posedge clk);
      #1;
    end

    // Burst split: req1 20-beat packet against req3 streaming
    for (int b = 0; b < 8; b++)  exp_q.push_back(din_of(1, 0, dat(1, b)));
    for (int b = 0; b < 8; b++)  exp_q.push_back(din_of(3, 0, dat(3, b)));
    for (int b = 8; b < 16; b++) exp_q.push_back(din_of(1, 0, dat(1, b)));
    for (int b = 8; b < 16; b++) exp_q.push_back(din_of(3, 0, dat(3, b)));
    for (int b = 16; b < 20; b++)
      exp_q.push_back(din_of(1, b == 19, dat(1, b)));
    do_reset();
    c1 = 0; c3 = 0; cyc = 0; done = 0; last_cyc = -1;
    while (!done && cyc < 200) begin
      s_valid = 4'b1010;
      s_last  = {1'b0, 1'b0, c1 == 19, 1'b0};
      s_data[1*W +: W] = dat(1, c1);
      s_data[3*W +: W] = dat(3, c3);
      @(negedge clk);
      if (fifo_we) got_q.push_back(fifo_din);
      if (s_ready[1] && s_valid[1]) begin
        if (c1 == 19) begin
          done = 1;
          last_cyc = cyc;
        end
        c1++;
      end
      if (s_ready[3] && s_valid[3]) c3++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("burst_done", 64'(done), 1);
    chk("burst_nbeats", 64'(got_q.size()), 36);
    chk("burst_last_cyc", 64'(last_cyc), 40);
    for (int k = 0; k < 36 && k < got_q.size(); k++)
      chk($sformatf("burst_b%0d", k), 64'(got_q[k]),
          64'(exp_q[k]));

    // Write-side reset busy blocks grants; req0 first afterwards
    do_reset();
    s_valid = 4'hF;
    fifo_wr_rst_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("busy_gv", 64'(grant_valid), 0);
      chk("busy_rdy", 64'(s_ready), 0);
      @(posedge clk);
      #1;
    end
    fifo_wr_rst_busy = 1'b0;
    @(negedge clk);
    chk("busy_rel_gv0", 64'(grant_valid), 0);
    @(posedge clk);
    #1;
    chk("busy_rel_gv", 64'(grant_valid), 1);
    chk("busy_rel_gid", 64'(grant_id), 0);
    chk("busy_rel_rdy", 64'(s_ready), 1);

    // Async reset in the middle of a packet
    do_reset();
    s_valid = 4'h4;
    s_data[2*W +: W] = dat(2, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_bc", 64'(beat_count), 2);
    chk("mid_we", 64'(fifo_we), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_rdy", 64'(s_ready), 0);
    chk("arst_we", 64'(fifo_we), 0);
    chk("arst_gv", 64'(grant_valid), 0);
    chk("arst_bc", 64'(beat_count), 0);
    s_valid = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_rel_gv", 64'(grant_valid), 1);
    chk("arst_rel_gid", 64'(grant_id), 0);
    chk("arst_rel_bc", 64'(beat_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
